fir_sm_fifo: RTL and testbench
==============================

FIR_SM_FIFO -- requirements
Module: fir_sm_fifo

Interface
REQ-001 Parameter pDATA_WIDTH, default 32, stream data width.
REQ-002 Parameter pDEPTH, default 8, FIFO entries; power of two, minimum 2.
REQ-003 Parameter pLEN_WIDTH, default 12, width of frame-length config and sample counter.
REQ-004 axis_clk  in  1  sole clock; all state updates on rising edge.
REQ-005 axis_rst  in  1  reset; one clock; reset is synchronous and active-high.
REQ-006 s_tvalid  in  1  upstream FIR output-stream valid.
REQ-007 s_tdata  in  pDATA_WIDTH  upstream FIR output sample.
REQ-008 s_tlast  in  1  upstream last-sample marker.
REQ-009 s_tready  out  1  space available; feeds FIR sm_tready.
REQ-010 m_tvalid  out  1  downstream valid.
REQ-011 m_tdata  out  pDATA_WIDTH  downstream sample.
REQ-012 m_tlast  out  1  downstream last marker, carried with its sample.
REQ-013 m_tready  in  1  downstream ready.
REQ-014 cfg_len  in  pLEN_WIDTH  expected samples per frame; sampled at each accepted beat.
REQ-015 level  out  log2(pDEPTH)+1  current occupancy.
REQ-016 frame_active  out  1  high between first and last accepted beat of a frame.
REQ-017 frame_done  out  1  one-cycle pulse after a tlast beat is accepted.
REQ-018 err_len  out  1  sticky frame-length mismatch flag.
REQ-019 err_clr  in  1  clears err_len.

Function
REQ-020 Push when s_tvalid & s_tready; pop when m_tvalid & m_tready; {tlast,tdata} stored per entry.
REQ-021 s_tready SHALL equal (level != pDEPTH), derived from registered occupancy only; no dependence on m_tready.
REQ-022 m_tvalid SHALL equal (level != 0); m_tdata/m_tlast show the oldest entry (first-word fall-through); a push into an empty FIFO is visible on m_* the next cycle (latency 1).
REQ-023 Simultaneous push and pop: level unchanged, both pointers advance; pointers wrap modulo pDEPTH.
REQ-024 m_tdata/m_tlast SHALL hold stable while m_tvalid & !m_tready.
REQ-025 Frame FSM: IDLE -> ACTIVE on accepted beat with s_tlast=0; ACTIVE -> IDLE on accepted beat with s_tlast=0 never, with s_tlast=1 always; IDLE stays IDLE on single-beat frame (tlast on first beat); frame_active = (state==ACTIVE).
REQ-026 Sample counter cnt increments per accepted beat, saturates at all-ones, returns to 0 on accepted tlast beat.
REQ-027 frame_done pulses in the cycle after an accepted tlast beat.

Reset
REQ-028 axis_rst=1 at a clock edge: pointers, level, cnt cleared; FSM to IDLE; frame_done=0; err_len=0; stored data discarded.
REQ-029 Resulting outputs: s_tready=1, m_tvalid=0, m_tdata=0, m_tlast=0, level=0, frame_active=0.
REQ-030 Reset mid-frame or with FIFO non-empty SHALL drop all contents with no m_* beat emitted afterwards.

Configuration
REQ-031 Macro FIR_SM_FIFO_LEN_CHECK_EN defined: on accepted beat, err_len set next cycle if (s_tlast and cnt+1 != cfg_len) or (!s_tlast and cnt+1 == cfg_len).
REQ-032 Set and err_clr in the same cycle: set wins; err_clr alone clears err_len next cycle.
REQ-033 Macro undefined: err_len tied 0, err_clr ignored, no comparator logic; all other behaviour identical.

Verification
REQ-034 cfg_len=11, 11 beats data 1..11, tlast on 11th, m_tready=1 -> same 11 values out in order, m_tlast on 11, frame_done one pulse, err_len=0.
REQ-035 m_tready=0, push 9 beats (pDEPTH=8) -> s_tready low after 8th accept, level=8, 9th held upstream; raise m_tready -> 9th accepted one cycle after first pop.
REQ-036 level=4, s_tvalid=m_tready=1 continuously -> level stays 4 and output order preserved across pointer wrap.
REQ-037 LEN_CHECK_EN, cfg_len=11, tlast on 10th beat -> err_len=1 next cycle; err_clr and new mismatch same cycle -> err_len stays 1; err_clr alone -> 0.
REQ-038 axis_rst pulse with level=5 mid-frame -> next cycle level=0, m_tvalid=0, frame_active=0, s_tready=1; following frame of 11 beats passes cleanly.

Source files
------------

// File: rtl/fir_sm_fifo.sv
// FIR output-stream FIFO with frame tracking, occupancy and sample counter.
// Optional frame-length checking is enabled by defining FIR_SM_FIFO_LEN_CHECK_EN.
module fir_sm_fifo #(
    parameter int pDATA_WIDTH = 32,
    parameter int pDEPTH      = 8,
    parameter int pLEN_WIDTH  = 12
) (
    input  logic                     axis_clk,
    input  logic                     axis_rst,
    input  logic                     s_tvalid,
    input  logic [pDATA_WIDTH-1:0]   s_tdata,
    input  logic                     s_tlast,
    output logic                     s_tready,
    output logic                     m_tvalid,
    output logic [pDATA_WIDTH-1:0]   m_tdata,
    output logic                     m_tlast,
    input  logic                     m_tready,
    input  logic [pLEN_WIDTH-1:0]    cfg_len,
    output logic [$clog2(pDEPTH):0]  level,
    output logic                     frame_active,
    output logic                     frame_done,
    output logic                     err_len,
    input  logic                     err_clr
);

    localparam int AW = $clog2(pDEPTH);
    localparam int LW = AW + 1;

    typedef enum logic {IDLE, ACTIVE} state_t;

    logic [pDATA_WIDTH:0]  mem_q [pDEPTH];
    logic [pDATA_WIDTH:0]  rd_entry;
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]         level_q, level_d;
    state_t                state_q, state_d;
    logic [pLEN_WIDTH-1:0] cnt_q, cnt_d;
    logic                  frame_done_q, frame_done_d;
    logic                  push, pop;

    // Handshake flags come from registered occupancy only.
    assign s_tready = (level_q != LW'(pDEPTH));
    assign m_tvalid = (level_q != '0);
    assign push     = s_tvalid & s_tready;
    assign pop      = m_tvalid & m_tready;

    // Output is forced to zero while empty so stale RAM contents never appear.
    assign rd_entry     = mem_q[rd_ptr_q];
    assign m_tdata      = m_tvalid ? rd_entry[pDATA_WIDTH-1:0] : '0;
    assign m_tlast      = m_tvalid ? rd_entry[pDATA_WIDTH] : 1'b0;
    assign level        = level_q;
    assign frame_active = (state_q == ACTIVE);
    assign frame_done   = frame_done_q;

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        level_d      = level_q;
        state_d      = state_q;
        cnt_d        = cnt_q;
        frame_done_d = 1'b0;
        if (push) begin
            wr_ptr_d     = wr_ptr_q + 1'b1;
            state_d      = s_tlast ? IDLE : ACTIVE;
            frame_done_d = s_tlast;
            if (s_tlast) begin
                cnt_d = '0;
            end else if (cnt_q != '1) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge axis_clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {s_tlast, s_tdata};
        end
    end

    always_ff @(posedge axis_clk) begin
        if (axis_rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            state_q      <= IDLE;
            cnt_q        <= '0;
            frame_done_q <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            frame_done_q <= frame_done_d;
        end
    end

`ifdef FIR_SM_FIFO_LEN_CHECK_EN
    logic                  err_len_q, err_len_d;
    logic [pLEN_WIDTH:0]   cnt_inc;
    logic                  len_hit;
    logic                  len_mismatch;

    // Extra bit keeps a saturated counter from wrapping into a false match.
    assign cnt_inc      = {1'b0, cnt_q} + 1'b1;
    assign len_hit      = (cnt_inc == {1'b0, cfg_len});
    assign len_mismatch = push & (s_tlast ? !len_hit : len_hit);

    always_comb begin
        err_len_d = err_len_q;
        if (len_mismatch) begin
            err_len_d = 1'b1;
        end else if (err_clr) begin
            err_len_d = 1'b0;
        end
    end

    always_ff @(posedge axis_clk) begin
        if (axis_rst) begin
            err_len_q <= 1'b0;
        end else begin
            err_len_q <= err_len_d;
        end
    end

    assign err_len = err_len_q;
`else
    logic unused_len_inputs;
    assign unused_len_inputs = ^{err_clr, cfg_len};
    assign err_len           = 1'b0;
`endif

endmodule

// File: tb/tb_fir_sm_fifo.sv
// Directed bench for fir_sm_fifo: a per-cycle vector table plus frame,
// back-pressure, wrap, reset and length-check sequences with a scoreboard.
module tb_fir_sm_fifo;

    logic        axis_clk = 1'b0;
    logic        axis_rst;
    logic        s_tvalid;
    logic [31:0] s_tdata;
    logic        s_tlast;
    logic        s_tready;
    logic        m_tvalid;
    logic [31:0] m_tdata;
    logic        m_tlast;
    logic        m_tready;
    logic [11:0] cfg_len;
    logic [3:0]  level;
    logic        frame_active;
    logic        frame_done;
    logic        err_len;
    logic        err_clr;

    int n_cmp = 0;
    int n_bad = 0;
    int fd_cnt = 0;
    logic [32:0] exp_q [$];

    fir_sm_fifo #(.pDATA_WIDTH(32), .pDEPTH(8), .pLEN_WIDTH(12)) dut (
        .axis_clk(axis_clk), .axis_rst(axis_rst),
        .s_tvalid(s_tvalid), .s_tdata(s_tdata), .s_tlast(s_tlast), .s_tready(s_tready),
        .m_tvalid(m_tvalid), .m_tdata(m_tdata), .m_tlast(m_tlast), .m_tready(m_tready),
        .cfg_len(cfg_len), .level(level), .frame_active(frame_active),
        .frame_done(frame_done), .err_len(err_len), .err_clr(err_clr)
    );

    always #5 axis_clk = ~axis_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic        rst;
        logic        sv;
        logic [31:0] sd;
        logic        sl;
        logic        mr;
        logic [11:0] cl;
        logic [3:0]  lvl;
        logic        srdy;
        logic        mv;
        logic [31:0] md;
        logic        ml;
        logic        fa;
        logic        fd;
    } vec_t;

    vec_t vecs [11];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge axis_clk);
        #1;
    endtask

    // One clock with scoreboard bookkeeping for the beats crossing this edge.
    task automatic cyc();
        if (m_tvalid && m_tready) begin
            if (exp_q.size() == 0) begin
                chk("pop_unexpected", 64'(exp_q.size()), 64'd1);
            end else begin
                chk("pop_beat", {31'd0, m_tlast, m_tdata}, {31'd0, exp_q.pop_front()});
            end
        end
        if (s_tvalid && s_tready) begin
            exp_q.push_back({s_tlast, s_tdata});
        end
        step();
        if (frame_done) fd_cnt++;
    endtask

    task automatic send(input logic [31:0] d, input logic last);
        int n;
        s_tvalid = 1'b1;
        s_tdata  = d;
        s_tlast  = last;
        n = 0;
        while (!s_tready && n < 50) begin
            cyc();
            n++;
        end
        if (n >= 50) chk("send_timeout", 64'(n), 64'd0);
        cyc();
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic do_reset();
        axis_rst = 1'b1;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        m_tready = 1'b0;
        err_clr  = 1'b0;
        step();
        axis_rst = 1'b0;
        exp_q.delete();
        fd_cnt = 0;
    endtask

    task automatic drain(input string tag);
        int n;
        m_tready = 1'b1;
        s_tvalid = 1'b0;
        n = 0;
        while (level != 4'd0 && n < 30) begin
            cyc();
            n++;
        end
        cyc();
        chk({tag, "_left"}, 64'(exp_q.size()), 64'd0);
        chk({tag, "_level"}, 64'(level), 64'd0);
    endtask

    function automatic vec_t mkv(
        input logic rst, input logic sv, input logic [31:0] sd, input logic sl,
        input logic mr, input logic [11:0] cl, input logic [3:0] lvl,
        input logic srdy, input logic mv, input logic [31:0] md, input logic ml,
        input logic fa, input logic fd);
        vec_t v;
        v.rst = rst; v.sv = sv; v.sd = sd; v.sl = sl; v.mr = mr; v.cl = cl;
        v.lvl = lvl; v.srdy = srdy; v.mv = mv; v.md = md; v.ml = ml; v.fa = fa; v.fd = fd;
        return v;
    endfunction

    task automatic frame11(input string tag);
        cfg_len  = 12'd11;
        m_tready = 1'b1;
        fd_cnt   = 0;
        for (int i = 1; i <= 11; i++) begin
            send(32'(i), (i == 11));
        end
        drain(tag);
        chk({tag, "_frame_done_pulses"}, 64'(fd_cnt), 64'd1);
        chk({tag, "_err_len"}, 64'(err_len), 64'd0);
        chk({tag, "_frame_active"}, 64'(frame_active), 64'd0);
    endtask

    initial begin
        axis_rst = 1'b1;
        s_tvalid = 1'b0;
        s_tdata  = '0;
        s_tlast  = 1'b0;
        m_tready = 1'b0;
        cfg_len  = 12'd3;
        err_clr  = 1'b0;

        //              rst   sv    data       sl    mr    cfg     lvl   srdy  mv    m_tdata    ml    fa    fd
        vecs[0]  = mkv(1'b1, 1'b0, 32'h0,  1'b0, 1'b0, 12'd3, 4'd0, 1'b1, 1'b0, 32'h0,  1'b0, 1'b0, 1'b0);
        vecs[1]  = mkv(1'b0, 1'b1, 32'hA1, 1'b0, 1'b0, 12'd3, 4'd1, 1'b1, 1'b1, 32'hA1, 1'b0, 1'b1, 1'b0);
        vecs[2]  = mkv(1'b0, 1'b1, 32'hA2, 1'b0, 1'b0, 12'd3, 4'd2, 1'b1, 1'b1, 32'hA1, 1'b0, 1'b1, 1'b0);
        vecs[3]  = mkv(1'b0, 1'b1, 32'hA3, 1'b1, 1'b0, 12'd3, 4'd3, 1'b1, 1'b1, 32'hA1, 1'b0, 1'b0, 1'b1);
        vecs[4]  = mkv(1'b0, 1'b0, 32'h0,  1'b0, 1'b1, 12'd3, 4'd2, 1'b1, 1'b1, 32'hA2, 1'b0, 1'b0, 1'b0);
        vecs[5]  = mkv(1'b0, 1'b1, 32'hB1, 1'b1, 1'b1, 12'd1, 4'd2, 1'b1, 1'b1, 32'hA3, 1'b1, 1'b0, 1'b1);
        vecs[6]  = mkv(1'b0, 1'b0, 32'h0,  1'b0, 1'b1, 12'd1, 4'd1, 1'b1, 1'b1, 32'hB1, 1'b1, 1'b0, 1'b0);
        vecs[7]  = mkv(1'b0, 1'b0, 32'h0,  1'b0, 1'b1, 12'd1, 4'd0, 1'b1, 1'b0, 32'h0,  1'b0, 1'b0, 1'b0);
        vecs[8]  = mkv(1'b0, 1'b1, 32'hC1, 1'b0, 1'b1, 12'd3, 4'd1, 1'b1, 1'b1, 32'hC1, 1'b0, 1'b1, 1'b0);
        vecs[9]  = mkv(1'b1, 1'b1, 32'hC2, 1'b0, 1'b0, 12'd3, 4'd0, 1'b1, 1'b0, 32'h0,  1'b0, 1'b0, 1'b0);
        vecs[10] = mkv(1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 12'd3, 4'd0, 1'b1, 1'b0, 32'h0,  1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 11; i++) begin
            axis_rst = vecs[i].rst;
            s_tvalid = vecs[i].sv;
            s_tdata  = vecs[i].sd;
            s_tlast  = vecs[i].sl;
            m_tready = vecs[i].mr;
            cfg_len  = vecs[i].cl;
            step();
            chk($sformatf("v%0d_level", i),        64'(level),        64'(vecs[i].lvl));
            chk($sformatf("v%0d_s_tready", i),     64'(s_tready),     64'(vecs[i].srdy));
            chk($sformatf("v%0d_m_tvalid", i),     64'(m_tvalid),     64'(vecs[i].mv));
            chk($sformatf("v%0d_m_tdata", i),      64'(m_tdata),      64'(vecs[i].md));
            chk($sformatf("v%0d_m_tlast", i),      64'(m_tlast),      64'(vecs[i].ml));
            chk($sformatf("v%0d_frame_active", i), 64'(frame_active), 64'(vecs[i].fa));
            chk($sformatf("v%0d_frame_done", i),   64'(frame_done),   64'(vecs[i].fd));
            chk($sformatf("v%0d_err_len", i),      64'(err_len),      64'd0);
        end

        // Eleven-beat frame streaming straight through.
        do_reset();
        frame11("frame11");

        // Back-pressure: fill to full, ninth beat waits for the first pop.
        do_reset();
        cfg_len = 12'd9;
        for (int i = 0; i < 8; i++) send(32'(10 + i), 1'b0);
        chk("full_level", 64'(level), 64'd8);
        chk("full_s_tready", 64'(s_tready), 64'd0);
        s_tvalid = 1'b1;
        s_tdata  = 32'd18;
        s_tlast  = 1'b1;
        cyc();
        cyc();
        chk("held_level", 64'(level), 64'd8);
        chk("held_m_tdata", 64'(m_tdata), 64'd10);
        m_tready = 1'b1;
        cyc();
        chk("first_pop_level", 64'(level), 64'd7);
        chk("first_pop_s_tready", 64'(s_tready), 64'd1);
        chk("first_pop_m_tdata", 64'(m_tdata), 64'd11);
        cyc();
        chk("ninth_accept_level", 64'(level), 64'd7);
        chk("ninth_accept_frame_done", 64'(frame_done), 64'd1);
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        drain("bp_drain");

        // Steady push+pop at level 4 across pointer wrap.
        do_reset();
        for (int i = 0; i < 4; i++) send(32'(100 + i), 1'b0);
        chk("wrap_pre_level", 64'(level), 64'd4);
        m_tready = 1'b1;
        s_tvalid = 1'b1;
        for (int k = 0; k < 12; k++) begin
            s_tdata = 32'(104 + k);
            s_tlast = (k == 11);
            cyc();
            chk($sformatf("wrap_level_%0d", k), 64'(level), 64'd4);
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        drain("wrap_drain");

        // Reset mid-frame with five entries queued.
        do_reset();
        for (int i = 0; i < 5; i++) send(32'(200 + i), 1'b0);
        chk("prerst_level", 64'(level), 64'd5);
        chk("prerst_frame_active", 64'(frame_active), 64'd1);
        axis_rst = 1'b1;
        step();
        axis_rst = 1'b0;
        exp_q.delete();
        chk("rst_level", 64'(level), 64'd0);
        chk("rst_m_tvalid", 64'(m_tvalid), 64'd0);
        chk("rst_frame_active", 64'(frame_active), 64'd0);
        chk("rst_s_tready", 64'(s_tready), 64'd1);
        chk("rst_m_tdata", 64'(m_tdata), 64'd0);
        m_tready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("rst_no_beat_%0d", i), 64'(m_tvalid), 64'd0);
        end
        frame11("post_rst");

`ifdef FIR_SM_FIFO_LEN_CHECK_EN
        // Short frame, then clear racing a new mismatch, then clear alone.
        do_reset();
        cfg_len  = 12'd11;
        m_tready = 1'b1;
        for (int i = 1; i <= 9; i++) send(32'(i), 1'b0);
        chk("len_before_err", 64'(err_len), 64'd0);
        send(32'd10, 1'b1);
        chk("len_short_err", 64'(err_len), 64'd1);
        err_clr = 1'b1;
        send(32'd50, 1'b1);
        chk("len_clr_vs_set", 64'(err_len), 64'd1);
        cyc();
        err_clr = 1'b0;
        chk("len_clr_alone", 64'(err_len), 64'd0);
        cyc();
        chk("len_stays_clear", 64'(err_len), 64'd0);
        drain("len_drain");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
